// File: rtl/mem_access_ctrl.sv
// Initiator side of the 16-bit CPU data-memory port: sequences one load/store at a time
// against DataMemory and returns read data with a one-cycle Done pulse.
// Optional feature macro: MEM_BOUNDS_CHECK_EN (address range check against MEM_DEPTH).
module mem_access_ctrl #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 16,
  parameter int READ_LAT  = 1,
  parameter int MEM_DEPTH = 256
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              Req,
  input  logic              ReqWrite,
  input  logic [ADDR_W-1:0] ReqAddr,
  input  logic [DATA_W-1:0] ReqData,
  output logic              Ready,
  output logic              Done,
  output logic [DATA_W-1:0] RdData,
  output logic              Err,
  output logic [ADDR_W-1:0] Adresa,
  output logic [DATA_W-1:0] WriteData,
  output logic              MemWrite,
  output logic              MemRead,
  input  logic [DATA_W-1:0] ReadData
);

  localparam int CNT_W = (READ_LAT > 0) ? $clog2(READ_LAT + 1) : 1;

`ifdef MEM_BOUNDS_CHECK_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DONE
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              ready_nxt, done_nxt, err_nxt;
  logic              mem_write_nxt, mem_read_nxt;
  logic [DATA_W-1:0] rd_data_nxt, wdata_nxt;
  logic [ADDR_W-1:0] adresa_nxt;
  logic              out_of_range;

  // With the check disabled this folds to a constant 0, so Err is effectively tied low.
  assign out_of_range = BOUNDS_EN && ($unsigned(32'(ReqAddr)) >= $unsigned(32'(MEM_DEPTH)));

  // Every output is the registered copy of a *_nxt value computed below.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    state_nxt     = state;
    cnt_nxt       = cnt;
    ready_nxt     = 1'b0;
    done_nxt      = 1'b0;
    err_nxt       = 1'b0;
    mem_write_nxt = 1'b0;
    mem_read_nxt  = 1'b0;
    rd_data_nxt   = RdData;
    adresa_nxt    = Adresa;
    wdata_nxt     = WriteData;

    unique case (state)
      S_IDLE: begin
        if (Ready && Req) begin
          if (out_of_range) begin
            state_nxt = S_DONE;
            done_nxt  = 1'b1;
            err_nxt   = 1'b1;
          end else if (ReqWrite) begin
            state_nxt     = S_WRITE;
            adresa_nxt    = ReqAddr;
            wdata_nxt     = ReqData;
            mem_write_nxt = 1'b1;
          end else begin
            state_nxt    = S_READ;
            adresa_nxt   = ReqAddr;
            mem_read_nxt = 1'b1;
            cnt_nxt      = CNT_W'(READ_LAT);
          end
        end else begin
          // Also covers the first edge after reset, where Ready is still low.
          ready_nxt = 1'b1;
        end
      end
      S_WRITE: begin
        state_nxt = S_DONE;
        done_nxt  = 1'b1;
      end
      S_READ: begin
        if (cnt == '0) begin
          rd_data_nxt = ReadData;
          state_nxt   = S_DONE;
          done_nxt    = 1'b1;
        end else begin
          cnt_nxt      = cnt - CNT_W'(1);
          mem_read_nxt = 1'b1;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
        ready_nxt = 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      Ready     <= 1'b0;
      Done      <= 1'b0;
      Err       <= 1'b0;
      RdData    <= '0;
      Adresa    <= '0;
      WriteData <= '0;
      MemWrite  <= 1'b0;
      MemRead   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all state updates together at the clock edge.
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      Ready     <= ready_nxt;
      Done      <= done_nxt;
      Err       <= err_nxt;
      RdData    <= rd_data_nxt;
      Adresa    <= adresa_nxt;
      WriteData <= wdata_nxt;
      MemWrite  <= mem_write_nxt;
      MemRead   <= mem_read_nxt;
    end
  end

endmodule
